// File: rtl/alu_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_arbiter_if
//
// Purpose: one requester's connection to alu_arbiter. It carries the
// operation handshake (valid/ready plus operands) and the result strobe that
// comes back to that requester. Each requester gets its own instance.
//
// Signals:
//   valid       requester presents an operation
//   ready       arbiter accepted the operation this cycle
//   a, b        32-bit operands
//   ctrl        3-bit ALU control code
//   rsp_valid   one-cycle result strobe back to this requester
//   rsp_result  captured ALU result (held between responses)
//   rsp_zero    captured ALU zero flag (held between responses)
//
// Modports:
//   master  requester side (drives valid/a/b/ctrl)
//   slave   arbiter side (drives ready and the response signals)
// ----------------------------------------------------------------------------
interface alu_arbiter_if;
    logic        valid;
    logic        ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctrl;
    logic        rsp_valid;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport master (
        output valid,
        output a,
        output b,
        output ctrl,
        input  ready,
        input  rsp_valid,
        input  rsp_result,
        input  rsp_zero
    );

    modport slave (
        input  valid,
        input  a,
        input  b,
        input  ctrl,
        output ready,
        output rsp_valid,
        output rsp_result,
        output rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// ----------------------------------------------------------------------------
// alu_arbiter
//
// Purpose: shares one combinational ALU between two requesters. An operation
// is accepted in IDLE, its operands are registered and presented to the ALU
// in EXEC, where the ALU output is captured, and the result is strobed back to
// the owning requester in RESP. Fixed latency of two cycles from accept to
// response; at most one operation every three cycles.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous active-high reset
//   req0, req1  requester buses (alu_arbiter_if.slave)
//   alu_a       operand A to the shared ALU (from operand register)
//   alu_b       operand B to the shared ALU (from operand register)
//   alu_ctrl    control code to the shared ALU (from operand register)
//   alu_result  combinational ALU result
//   alu_zero    combinational ALU zero flag
//   ops_done    16-bit count of completed operations, wraps silently
//
// Configuration:
//   ALU_ARB_RR_EN  when defined, a both-valid tie goes to the requester that
//                  did not win last (round-robin). When undefined, port 0
//                  always wins a tie and no last-grant state exists.
// ----------------------------------------------------------------------------
module alu_arbiter (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave req0,
    alu_arbiter_if.slave req1,
    output logic [31:0]  alu_a,
    output logic [31:0]  alu_b,
    output logic [2:0]   alu_ctrl,
    input  logic [31:0]  alu_result,
    input  logic         alu_zero,
    output logic [15:0]  ops_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]  state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [2:0]  op_ctrl;
    logic        owner;
    logic [31:0] res_q;
    logic        zero_q;
    logic [15:0] ops_count;
    logic        grant0;
    logic        grant1;
    logic        prefer0;

`ifdef ALU_ARB_RR_EN
    // last_grant = 1 means port 1 won most recently, so port 0 is favoured
    // on the next tie. Reset value 1 makes port 0 win the first tie.
    logic last_grant;

    assign prefer0 = last_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (state == RESP) begin
            last_grant <= owner;
        end
    end
`else
    assign prefer0 = 1'b1;
`endif

    // Grant is only possible in IDLE; a tie is resolved by prefer0. A
    // withdrawn request simply stops participating, nothing is remembered.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            if (req0.valid && (!req1.valid || prefer0)) begin
                grant0 = 1'b1;
            end else if (req1.valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0.ready = grant0;
    assign req1.ready = grant1;

    // Main sequencer: accept and register operands, capture ALU output, then
    // count the completed operation. A reset anywhere aborts the operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            op_ctrl   <= 3'd0;
            owner     <= 1'b0;
            res_q     <= 32'd0;
            zero_q    <= 1'b0;
            ops_count <= 16'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a    <= grant1 ? req1.a    : req0.a;
                        op_b    <= grant1 ? req1.b    : req0.b;
                        op_ctrl <= grant1 ? req1.ctrl : req0.ctrl;
                        owner   <= grant1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                    state  <= RESP;
                end
                RESP: begin
                    ops_count <= ops_count + 16'd1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The ALU only ever sees registered operands, never the requester inputs.
    assign alu_a    = op_a;
    assign alu_b    = op_b;
    assign alu_ctrl = op_ctrl;

    assign req0.rsp_valid  = (state == RESP) && !owner;
    assign req1.rsp_valid  = (state == RESP) && owner;
    assign req0.rsp_result = res_q;
    assign req1.rsp_result = res_q;
    assign req0.rsp_zero   = zero_q;
    assign req1.rsp_zero   = zero_q;

    assign ops_done = ops_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A small ALU stub supplies results; a
// cycle-level behavioural model (time since last accept, winner rule, held
// result, completion count) is compared against every DUT output on every
// negative clock edge, and directed vectors carry hand-computed literals.
// Build with +define+ALU_ARB_RR_EN to exercise round-robin arbitration.
// ----------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic [15:0] ops_done;

    int checks   = 0;
    int failures = 0;

    alu_arbiter_if req0_bus ();
    alu_arbiter_if req1_bus ();

    alu_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0       (req0_bus),
        .req1       (req1_bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .ops_done   (ops_done)
    );

    always #5 clk = ~clk;

    // ALU stub: small operation set selected by ctrl, zero flag from result.
    function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        case (c)
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return a + b;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_a, alu_b, alu_ctrl);
    assign alu_zero   = (alu_result == 32'd0);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] c0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [2:0] c1);
        req0_bus.valid = v0;
        req0_bus.a     = a0;
        req0_bus.b     = b0;
        req0_bus.ctrl  = c0;
        req1_bus.valid = v1;
        req1_bus.a     = a1;
        req1_bus.b     = b1;
        req1_bus.ctrl  = c1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model. age counts cycles since the last accept (1 = operands
    // at the ALU, 2 = response cycle, 3 = free to accept).
    // ------------------------------------------------------------------------
    int          age = 3;
    bit          armed = 1'b0;
    bit          preload_req = 1'b0;
    bit          preload_done = 1'b0;
    logic [31:0] m_a, m_b, res_hold;
    logic [2:0]  m_ctrl;
    logic        m_owner, m_zero, m_last;
    logic [15:0] exp_cnt;
    logic        e_r0, e_r1;

    always @(negedge clk) begin
        if (preload_req && !preload_done) begin
            exp_cnt      = 16'hFFFF;
            preload_done = 1'b1;
        end
        e_r0 = 1'b0;
        e_r1 = 1'b0;
        if (age >= 3) begin
            if (req0_bus.valid && req1_bus.valid) begin
`ifdef ALU_ARB_RR_EN
                if (m_last) e_r0 = 1'b1;
                else        e_r1 = 1'b1;
`else
                e_r0 = 1'b1;
`endif
            end else begin
                e_r0 = req0_bus.valid;
                e_r1 = req1_bus.valid;
            end
        end
        if (armed) begin
            checkOutput("cyc_ready0", 32'(req0_bus.ready), 32'(e_r0));
            checkOutput("cyc_ready1", 32'(req1_bus.ready), 32'(e_r1));
            checkOutput("cyc_rsp0_valid", 32'(req0_bus.rsp_valid), 32'(age == 2 && !m_owner));
            checkOutput("cyc_rsp1_valid", 32'(req1_bus.rsp_valid), 32'(age == 2 && m_owner));
            checkOutput("cyc_rsp0_result", req0_bus.rsp_result, res_hold);
            checkOutput("cyc_rsp1_result", req1_bus.rsp_result, res_hold);
            checkOutput("cyc_rsp0_zero", 32'(req0_bus.rsp_zero), 32'(m_zero));
            checkOutput("cyc_rsp1_zero", 32'(req1_bus.rsp_zero), 32'(m_zero));
            checkOutput("cyc_alu_a", alu_a, m_a);
            checkOutput("cyc_alu_b", alu_b, m_b);
            checkOutput("cyc_alu_ctrl", 32'(alu_ctrl), 32'(m_ctrl));
            checkOutput("cyc_ops_done", 32'(ops_done), 32'(exp_cnt));
        end
        if (reset) begin
            age      = 3;
            m_a      = 32'd0;
            m_b      = 32'd0;
            m_ctrl   = 3'd0;
            m_owner  = 1'b0;
            res_hold = 32'd0;
            m_zero   = 1'b0;
            exp_cnt  = 16'd0;
            m_last   = 1'b1;
            armed    = 1'b1;
        end else if (armed) begin
            if (age == 1) begin
                res_hold = alu_fn(m_a, m_b, m_ctrl);
                m_zero   = (res_hold == 32'd0);
            end
            if (age == 2) begin
                exp_cnt = exp_cnt + 16'd1;
                m_last  = m_owner;
            end
            if (e_r0 || e_r1) begin
                m_owner = e_r1;
                m_a     = e_r1 ? req1_bus.a    : req0_bus.a;
                m_b     = e_r1 ? req1_bus.b    : req0_bus.b;
                m_ctrl  = e_r1 ? req1_bus.ctrl : req0_bus.ctrl;
                age     = 1;
            end else if (age < 3) begin
                age = age + 1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed stimulus with literal expectations.
    // ------------------------------------------------------------------------
    typedef struct {
        logic        port;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[6];
    int   grants[$];
    int   rsp_cyc[$];
    int   collisions;
    int   exp_grant[4];

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        // Outputs right after reset
        @(negedge clk);
        checkOutput("reset_alu_a", alu_a, 32'd0);
        checkOutput("reset_rsp0_valid", 32'(req0_bus.rsp_valid), 32'd0);
        checkOutput("reset_rsp1_result", req1_bus.rsp_result, 32'd0);
        checkOutput("reset_ops_done", 32'(ops_done), 32'd0);
        tick();

        // Single op: 2 + 3 from port 0
        applyStimulus(1, 32'd2, 32'd3, 3'd0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("single_ready0", 32'(req0_bus.ready), 32'd1);
        checkOutput("single_ready1", 32'(req1_bus.ready), 32'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checkOutput("single_alu_a", alu_a, 32'd2);
        checkOutput("single_alu_b", alu_b, 32'd3);
        tick();
        @(negedge clk);
        checkOutput("single_rsp0_valid", 32'(req0_bus.rsp_valid), 32'd1);
        checkOutput("single_rsp0_result", req0_bus.rsp_result, 32'd5);
        checkOutput("single_rsp0_zero", 32'(req0_bus.rsp_zero), 32'd0);
        checkOutput("single_rsp1_valid", 32'(req1_bus.rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("single_ops_done", 32'(ops_done), 32'd1);
        checkOutput("single_rsp0_hold", req0_bus.rsp_result, 32'd5);
        tick();

        // Zero flag from port 1
        applyStimulus(0, 0, 0, 0, 1, 32'd0, 32'd0, 3'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checkOutput("zero_rsp1_valid", 32'(req1_bus.rsp_valid), 32'd1);
        checkOutput("zero_rsp1_zero", 32'(req1_bus.rsp_zero), 32'd1);
        checkOutput("zero_rsp1_result", req1_bus.rsp_result, 32'd0);
        checkOutput("zero_rsp0_valid", 32'(req0_bus.rsp_valid), 32'd0);
        tick();

        // Contention: both valid for four operations
`ifdef ALU_ARB_RR_EN
        exp_grant = '{0, 1, 0, 1};
`else
        exp_grant = '{0, 0, 0, 0};
`endif
        collisions = 0;
        applyStimulus(1, 32'd10, 32'd20, 3'd1, 1, 32'd7, 32'd7, 3'd2);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_bus.ready) grants.push_back(0);
            if (req1_bus.ready) grants.push_back(1);
            if (req0_bus.rsp_valid && req1_bus.rsp_valid) collisions++;
            if (req0_bus.rsp_valid || req1_bus.rsp_valid) rsp_cyc.push_back(c);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("contend_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4 && i < grants.size(); i++) begin
            checkOutput($sformatf("contend_grant%0d", i), 32'(grants[i]), 32'(exp_grant[i]));
        end
        checkOutput("contend_rsp_count", 32'(rsp_cyc.size()), 32'd4);
        for (int i = 1; i < rsp_cyc.size(); i++) begin
            checkOutput($sformatf("contend_spacing%0d", i), 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd3);
        end
        checkOutput("contend_collisions", 32'(collisions), 32'd0);

        // Withdrawn request: port 1 valid only while the block is busy
        applyStimulus(1, 32'd100, 32'd5, 3'd1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 1, 32'd9, 32'd9, 3'd0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        @(negedge clk);
        checkOutput("withdraw_ready1", 32'(req1_bus.ready), 32'd0);
        checkOutput("withdraw_prev_result", req0_bus.rsp_result, 32'd95);
        tick();

        // Reset in EXEC aborts the operation
        applyStimulus(1, 32'd40, 32'd2, 3'd0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_rsp0_valid", 32'(req0_bus.rsp_valid), 32'd0);
        checkOutput("abort_ops_done", 32'(ops_done), 32'd0);
        checkOutput("abort_alu_a", alu_a, 32'd0);
        checkOutput("abort_rsp0_result", req0_bus.rsp_result, 32'd0);
        tick();

        // Directed ALU vectors alternating between ports
        vecs[0] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        3'd0, 32'h0000_0000};
        vecs[1] = '{1'b1, 32'd5,         32'd7,        3'd1, 32'hFFFF_FFFE};
        vecs[2] = '{1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 3'd2, 32'h0000_00F0};
        vecs[3] = '{1'b1, 32'hA000_0000, 32'h0000_0005, 3'd3, 32'hA000_0005};
        vecs[4] = '{1'b0, 32'h0000_1234, 32'h0000_1234, 3'd4, 32'h0000_0000};
        vecs[5] = '{1'b1, 32'd100,       32'd23,       3'd7, 32'd123};
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].port)
                applyStimulus(0, 0, 0, 0, 1, vecs[i].a, vecs[i].b, vecs[i].ctrl);
            else
                applyStimulus(1, vecs[i].a, vecs[i].b, vecs[i].ctrl, 0, 0, 0, 0);
            tick();
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            tick();
            @(negedge clk);
            if (vecs[i].port) begin
                checkOutput($sformatf("vec%0d_rsp1_valid", i), 32'(req1_bus.rsp_valid), 32'd1);
                checkOutput($sformatf("vec%0d_result", i), req1_bus.rsp_result, vecs[i].res);
            end else begin
                checkOutput($sformatf("vec%0d_rsp0_valid", i), 32'(req0_bus.rsp_valid), 32'd1);
                checkOutput($sformatf("vec%0d_result", i), req0_bus.rsp_result, vecs[i].res);
            end
            checkOutput($sformatf("vec%0d_zero", i), 32'(req0_bus.rsp_zero),
                        32'(vecs[i].res == 32'd0));
            tick();
        end
        @(negedge clk);
        checkOutput("vec_ops_done", 32'(ops_done), 32'd6);
        tick();

        // Counter wrap: preload the completion counter, then one more op
        preload_req = 1'b1;
        dut.ops_count <= 16'hFFFF;
        @(negedge clk);
        checkOutput("wrap_preload", 32'(ops_done), 32'h0000_FFFF);
        tick();
        applyStimulus(1, 32'd1, 32'd1, 3'd0, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        checkOutput("wrap_ops_done", 32'(ops_done), 32'd0);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-003 reqN_ready  output  1  operation from requester N accepted this cycle.
REQ-004 reqN_a  input  32  operand A of requester N.
REQ-005 reqN_b  input  32  operand B of requester N.
REQ-006 reqN_ctrl  input  3  ALU control code of requester N.
REQ-007 rspN_valid  output  1  one-cycle result strobe to requester N.
REQ-008 rspN_result  output  32  captured ALU result; the same value is driven on both ports.
REQ-009 rspN_zero  output  1  captured ALU zero flag; the same value is driven on both ports.
REQ-010 alu_a  output  32  operand A driven to the shared ALU.
REQ-011 alu_b  output  32  operand B driven to the shared ALU.
REQ-012 alu_ctrl  output  3  control code driven to the shared ALU.
REQ-013 alu_result  input  32  combinational result from the shared ALU.
REQ-014 alu_zero  input  1  combinational zero flag from the shared ALU.
REQ-015 ops_done  output  16  count of completed operations.

Function
REQ-016 The FSM SHALL use three states, IDLE, EXEC and RESP, with transitions IDLE->EXEC on accept, EXEC->RESP always, and RESP->IDLE always.
REQ-017 In IDLE with at least one reqN_valid, the block SHALL combinationally assert exactly one reqN_ready for the winner, register that requester's a/b/ctrl and owner ID, and move to EXEC.
REQ-018 reqN_ready SHALL be 0 in EXEC and RESP, and in IDLE when reqN_valid=0.
REQ-019 alu_a, alu_b and alu_ctrl SHALL be driven only from the operand registers, never combinationally from the requester inputs.
REQ-020 In EXEC, the block SHALL capture alu_result and alu_zero into the result registers.
REQ-021 In RESP, the block SHALL assert rsp<owner>_valid for exactly one cycle, with no backpressure.
REQ-022 The other rspN_valid SHALL stay 0.
REQ-023 In RESP, the block SHALL increment ops_done by 1 and update the last-grant bit to the owner.
REQ-024 Latency SHALL be fixed: an accept in cycle t produces rsp_valid in cycle t+2.
REQ-025 Maximum throughput SHALL be one operation per 3 cycles.
REQ-026 Arbitration with a single valid requester SHALL grant that requester.
REQ-027 Arbitration with both requesters valid SHALL follow REQ-035/REQ-036.
REQ-028 A requester SHALL NOT be granted twice in a row while the other is continuously valid when ALU_ARB_RR_EN is defined.
REQ-029 ops_done SHALL wrap from 0xFFFF to 0x0000 without a flag.
REQ-030 rspN_result and rspN_zero SHALL hold their values between responses.
REQ-031 A requester deasserting valid before it is granted SHALL be legal; the block SHALL keep no memory of the withdrawn request.

Reset
REQ-032 While reset=1 at a clk edge, the block SHALL set the state to IDLE, clear all operand, result and owner registers, clear ops_done, and set the last-grant bit to 1, so that port 0 wins first.
REQ-033 All outputs SHALL be 0 in the cycle after reset.
REQ-034 A reset asserted in EXEC or RESP SHALL abort the operation with no rsp_valid and no ops_done increment.

Configuration
REQ-035 With ALU_ARB_RR_EN defined, a both-valid tie SHALL be granted to the requester not recorded in the last-grant bit (round-robin).
REQ-036 With ALU_ARB_RR_EN undefined, a both-valid tie SHALL always be granted to port 0 (fixed priority), and the last-grant bit SHALL be unused.

Verification
REQ-037 Single op: ALU stub returns a+b with zero=(sum==0); req0 a=2, b=3, ctrl=000 accepted at t -> alu_a=2, alu_b=3 at t+1; rsp0_valid=1, rsp0_result=5, rsp0_zero=0 at t+2; ops_done=1.
REQ-038 Contention with RR_EN: both valid continuously for 4 operations -> grant order 0,1,0,1; each response has 3-cycle spacing; rsp1 never coincides with rsp0.
REQ-039 Contention without RR_EN: both valid for 3 operations -> grants 0,0,0; req1_ready stays 0.
REQ-040 Zero flag: req1 a=0, b=0 -> rsp1_zero=1, rsp1_result=0, and rsp0_valid stays 0.
REQ-041 Reset mid-operation: reset asserted in EXEC -> no rsp_valid; the next cycle is IDLE with all outputs 0 and ops_done=0.
REQ-042 Wrap: preload ops_done to 0xFFFF by running 65535 operations, then run one more -> ops_done=0x0000.
